// File: rtl/doorlock_ctrl_if.sv
// Keypad-to-lock bus: debounced key strobes in, display/actuator status out.
interface doorlock_ctrl_if;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       key_enter;
   logic       key_clear;
   logic [1:0] status;
   logic       unlock;
   logic       lockout;
   logic [2:0] digit_cnt;

   modport master (
      output key_valid, key_digit, key_enter, key_clear,
      input  status, unlock, lockout, digit_cnt
   );

   modport slave (
      input  key_valid, key_digit, key_enter, key_clear,
      output status, unlock, lockout, digit_cnt
   );
endinterface

// File: rtl/doorlock_ctrl.sv
// Door-lock controller: buffers up to four BCD digits, checks them against
// PASSWORD on Enter, holds the door open for OPEN_CYCLES and locks out all
// input for LOCK_CYCLES after MAX_FAIL consecutive failures.
module doorlock_ctrl #(
   parameter logic [15:0] PASSWORD    = 16'h1234,
   parameter int          OPEN_CYCLES = 8,
   parameter int          LOCK_CYCLES = 16,
   parameter int          MAX_FAIL    = 3
) (
   input logic            clk,
   input logic            rst_n,
   doorlock_ctrl_if.slave bus
);

   localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
   localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAIL);

   localparam logic [1:0] S_CLOSED  = 2'd0;
   localparam logic [1:0] S_ENTRY   = 2'd1;
   localparam logic [1:0] S_OPEN    = 2'd2;
   localparam logic [1:0] S_LOCKOUT = 2'd3;

   localparam logic [1:0] ST_ENTRY  = 2'b00;
   localparam logic [1:0] ST_OPEN   = 2'b01;
   localparam logic [1:0] ST_CLOSED = 2'b10;

   logic [1:0]    state_q, state_d;
   logic [15:0]   buf_q, buf_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [2:0]    fail_q, fail_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [1:0]    status_q;
   logic          unlock_q, lockout_q;
   logic          dig_ok;

   // Next-state logic; clear beats enter beats digit, losers are dropped.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      tmr_d   = tmr_q;
      dig_ok  = bus.key_valid && (bus.key_digit <= 4'd9);
      case (state_q)
         S_CLOSED: begin
            // Enter/clear are no-ops here but still shadow a same-cycle digit.
            if (!bus.key_clear && !bus.key_enter && dig_ok) begin
               buf_d   = {12'h000, bus.key_digit};
               cnt_d   = 3'd1;
               state_d = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (bus.key_clear) begin
               buf_d   = 16'h0000;
               cnt_d   = 3'd0;
               state_d = S_CLOSED;
            end else if (bus.key_enter) begin
               buf_d = 16'h0000;
               cnt_d = 3'd0;
               if (cnt_q == 3'd4 && buf_q == PASSWORD) begin
                  state_d = S_OPEN;
                  fail_d  = 3'd0;
                  tmr_d   = '0;
               end else if (fail_q + 3'd1 == FAIL_MAX) begin
                  state_d = S_LOCKOUT;
                  tmr_d   = '0;
               end else begin
                  fail_d  = fail_q + 3'd1;
                  state_d = S_CLOSED;
               end
            end else if (dig_ok && cnt_q < 3'd4) begin
               buf_d = {buf_q[11:0], bus.key_digit};
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_OPEN: begin
            if (bus.key_enter || tmr_q == OPEN_LAST) begin
               state_d = S_CLOSED;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_LOCKOUT: begin
            if (tmr_q == LOCK_LAST) begin
               state_d = S_CLOSED;
               fail_d  = 3'd0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: state_d = S_CLOSED;
      endcase
   end

   // State, buffer and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_CLOSED;
         buf_q   <= 16'h0000;
         cnt_q   <= 3'd0;
         fail_q  <= 3'd0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         fail_q  <= fail_d;
         tmr_q   <= tmr_d;
      end
   end

   // Output registers decoded from the next state so they track state_q exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q  <= ST_CLOSED;
         unlock_q  <= 1'b0;
         lockout_q <= 1'b0;
      end else begin
         unlock_q  <= (state_d == S_OPEN);
         lockout_q <= (state_d == S_LOCKOUT);
         case (state_d)
            S_ENTRY: status_q <= ST_ENTRY;
            S_OPEN:  status_q <= ST_OPEN;
            default: status_q <= ST_CLOSED;
         endcase
      end
   end

   assign bus.status    = status_q;
   assign bus.unlock    = unlock_q;
   assign bus.lockout   = lockout_q;
   assign bus.digit_cnt = cnt_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Bench for doorlock_ctrl: directed scenarios plus random key sessions,
// checked every cycle against a digit-queue / countdown reference model.
module tb_doorlock_ctrl;
   localparam logic [15:0] PW     = 16'h1234;
   localparam int          OPEN_N = 8;
   localparam int          LOCK_N = 16;
   localparam int          MAXF   = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   doorlock_ctrl_if bus();

   doorlock_ctrl #(
      .PASSWORD(PW), .OPEN_CYCLES(OPEN_N), .LOCK_CYCLES(LOCK_N), .MAX_FAIL(MAXF)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: digits typed so far, and cycles left in open / lockout.
   int m_q[$];
   bit m_entry;
   int m_fails;
   int m_open_left;
   int m_lock_left;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function void model_reset();
      m_q.delete();
      m_entry     = 1'b0;
      m_fails     = 0;
      m_open_left = 0;
      m_lock_left = 0;
   endfunction

   function void model_step(input bit v, input int d, input bit e, input bit c);
      bit dig;
      int val;
      dig = v && (d <= 9);
      val = 0;
      if (m_lock_left > 0) begin
         m_lock_left--;
         if (m_lock_left == 0) m_fails = 0;
      end else if (m_open_left > 0) begin
         if (e) m_open_left = 0;
         else   m_open_left--;
      end else if (m_entry) begin
         if (c) begin
            m_entry = 1'b0;
            m_q.delete();
         end else if (e) begin
            foreach (m_q[i]) val = val * 16 + m_q[i];
            if (m_q.size() == 4 && val == int'(PW)) begin
               m_open_left = OPEN_N;
               m_fails     = 0;
            end else begin
               m_fails++;
               if (m_fails == MAXF) m_lock_left = LOCK_N;
            end
            m_entry = 1'b0;
            m_q.delete();
         end else if (dig && m_q.size() < 4) begin
            m_q.push_back(d);
         end
      end else if (dig && !c && !e) begin
         m_entry = 1'b1;
         m_q.push_back(d);
      end
   endfunction

   task automatic check_outputs(input string tag);
      int exp_st;
      if (m_lock_left > 0)      exp_st = 2;
      else if (m_open_left > 0) exp_st = 1;
      else if (m_entry)         exp_st = 0;
      else                      exp_st = 2;
      chk({tag, ".status"},    int'(bus.status),    exp_st);
      chk({tag, ".unlock"},    int'(bus.unlock),    int'(m_open_left > 0));
      chk({tag, ".lockout"},   int'(bus.lockout),   int'(m_lock_left > 0));
      chk({tag, ".digit_cnt"}, int'(bus.digit_cnt), m_q.size());
   endtask

   // One clock: present strobes, let the edge take them, check just after.
   task automatic step(input bit v, input logic [3:0] d, input bit e, input bit c,
                       input string tag = "rnd");
      bus.key_valid = v;
      bus.key_digit = d;
      bus.key_enter = e;
      bus.key_clear = c;
      @(posedge clk);
      model_step(v, int'(d), e, c);
      #1;
      bus.key_valid = 1'b0;
      bus.key_digit = 4'h0;
      bus.key_enter = 1'b0;
      bus.key_clear = 1'b0;
      check_outputs(tag);
   endtask

   task automatic idle(input int n, input string tag);
      repeat (n) step(1'b0, 4'h0, 1'b0, 1'b0, tag);
   endtask

   task automatic enter_code(input logic [15:0] code, input string tag);
      for (int i = 3; i >= 0; i--) step(1'b1, code[i*4 +: 4], 1'b0, 1'b0, tag);
      step(1'b0, 4'h0, 1'b1, 1'b0, tag);
   endtask

   initial begin
      bus.key_valid = 1'b0;
      bus.key_digit = 4'h0;
      bus.key_enter = 1'b0;
      bus.key_clear = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #12;
      chk("rst.status",    int'(bus.status),    2);
      chk("rst.unlock",    int'(bus.unlock),    0);
      chk("rst.lockout",   int'(bus.lockout),   0);
      chk("rst.digit_cnt", int'(bus.digit_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Correct code opens for OPEN_N cycles.
      enter_code(PW, "good");
      idle(10, "good");

      // Wrong then short entry, third failure locks out.
      enter_code(16'h1235, "wrong");
      step(1'b1, 4'h9, 1'b0, 1'b0, "short");
      step(1'b0, 4'h0, 1'b1, 1'b0, "short");
      step(1'b1, 4'h1, 1'b0, 1'b0, "third");
      step(1'b0, 4'h0, 1'b1, 1'b0, "third");
      for (int i = 0; i < LOCK_N + 2; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "lock");
      enter_code(PW, "postlock");
      idle(10, "postlock");

      // Clear, overflow digit, invalid digit.
      step(1'b1, 4'h1, 1'b0, 1'b0, "clear");
      step(1'b1, 4'h2, 1'b0, 1'b0, "clear");
      step(1'b0, 4'h0, 1'b0, 1'b1, "clear");
      for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0, "ovf");
      step(1'b1, 4'h7, 1'b0, 1'b0, "ovf");
      step(1'b0, 4'h0, 1'b1, 1'b0, "ovf");
      idle(10, "ovf");
      step(1'b1, 4'hA, 1'b0, 1'b0, "inval");

      // Same-cycle strobes.
      for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0, "entclr");
      step(1'b0, 4'h0, 1'b1, 1'b1, "entclr");
      for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0, "entdig");
      step(1'b1, 4'h5, 1'b1, 1'b0, "entdig");
      idle(10, "entdig");

      // Relock by Enter during the third open cycle.
      enter_code(PW, "relock");
      idle(2, "relock");
      step(1'b0, 4'h0, 1'b1, 1'b0, "relock");
      idle(2, "relock");

      // Asynchronous reset while the door is open.
      enter_code(PW, "arst");
      idle(2, "arst");
      rst_n = 1'b0;
      #1;
      chk("arst.unlock", int'(bus.unlock), 0);
      chk("arst.status", int'(bus.status), 2);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(2, "arst");

      // Random sessions.
      repeat (300) begin
         case ($urandom_range(0, 3))
            0: enter_code(PW, "rnd.good");
            1: begin
               repeat ($urandom_range(0, 5))
                  step(1'b1, 4'($urandom_range(0, 9)), 1'b0, 1'b0, "rnd.dig");
               step(1'b0, 4'h0, 1'b1, 1'b0, "rnd.ent");
            end
            2: repeat (6)
               step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), "rnd.mix");
            default: idle(int'($urandom_range(0, 20)), "rnd.idle");
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
